x_top: RTL and testbench

- Self-contained keypad calculator top: PS/2 keyboard receiver, scan-code decoder, accumulator-based arithmetic engine over a 16-entry register file, 4-digit hex 7-segment driver and 8-bit GPO.
- Sits at chip top: the board supplies clock/reset and a PS/2 keyboard, and drives the display and LEDs.

---
 rtl/x_pkg.sv | 83 ++++++++
 rtl/x_if.sv | 8 +
 rtl/x_ps2_rx.sv | 78 +++++++
 rtl/x_top.sv | 182 ++++++++++++++++++
 tb/tb_x_top.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/x_pkg.sv
// Shared definitions for the keypad calculator: widths, operator encoding,
// register indices, scan codes and the make-code classifier.
package x_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_REGF_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam int R_ACC    = 0;
  localparam int R_ENTRY  = 1;
  localparam int R_OP     = 2;
  localparam int R_LAST   = 3;
  localparam int R_ACTIVE = 4;
  localparam int R_COUNT  = 5;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ADD    = 8'h79;
  localparam logic [7:0] SC_SUB    = 8'h7B;
  localparam logic [7:0] SC_MUL    = 8'h7C;
  localparam logic [7:0] SC_DIV    = 8'h4A;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_CLEAR  = 8'h66;
  localparam logic [7:0] SC_ALLCLR = 8'h76;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    K_UNKNOWN,
    K_DIGIT,
    K_OPER,
    K_ENTER,
    K_CLEAR,
    K_ALLCLR
  } key_e;

  typedef struct packed {
    key_e       kind;
    logic [3:0] digit;
    op_e        op;
  } key_t;

  // Keypad and top-row digit codes map to the same value.
  function automatic key_t decode_key(input logic [7:0] code);
    key_t k;
    k.kind  = K_UNKNOWN;
    k.digit = 4'd0;
    k.op    = OP_ADD;
    case (code)
      8'h70, 8'h45: begin k.kind = K_DIGIT; k.digit = 4'd0; end
      8'h69, 8'h16: begin k.kind = K_DIGIT; k.digit = 4'd1; end
      8'h72, 8'h1E: begin k.kind = K_DIGIT; k.digit = 4'd2; end
      8'h7A, 8'h26: begin k.kind = K_DIGIT; k.digit = 4'd3; end
      8'h6B, 8'h25: begin k.kind = K_DIGIT; k.digit = 4'd4; end
      8'h73, 8'h2E: begin k.kind = K_DIGIT; k.digit = 4'd5; end
      8'h74, 8'h36: begin k.kind = K_DIGIT; k.digit = 4'd6; end
      8'h6C, 8'h3D: begin k.kind = K_DIGIT; k.digit = 4'd7; end
      8'h75, 8'h3E: begin k.kind = K_DIGIT; k.digit = 4'd8; end
      8'h7D, 8'h46: begin k.kind = K_DIGIT; k.digit = 4'd9; end
      SC_ADD:    begin k.kind = K_OPER; k.op = OP_ADD; end
      SC_SUB:    begin k.kind = K_OPER; k.op = OP_SUB; end
      SC_MUL:    begin k.kind = K_OPER; k.op = OP_MUL; end
      SC_DIV:    begin k.kind = K_OPER; k.op = OP_DIV; end
      SC_ENTER:  k.kind = K_ENTER;
      SC_CLEAR:  k.kind = K_CLEAR;
      SC_ALLCLR: k.kind = K_ALLCLR;
      default:   k.kind = K_UNKNOWN;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/x_if.sv
// Received-byte handshake between the PS/2 receiver and the decoder.
interface x_if;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (output byte_valid, output byte_data);
  modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/x_ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the lines, samples data on each
// falling ps2_clk edge and emits one byte_valid pulse per well-framed byte.
module x_ps2_rx
  import x_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  x_if.master  rx
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_valid_q;
  logic       fall;
  logic       din;

  assign din  = data_sync_q[1];
  assign fall = clk_prev_q & ~clk_sync_q[1];

  // Idle PS/2 lines are high, so the synchronisers come out of reset high
  // to avoid a phantom falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (fall) begin
        case (state_q)
          RX_IDLE: begin
            if (!din) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          RX_DATA: begin
            shift_q   <= {din, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: state_q <= RX_STOP;
          RX_STOP: begin
            state_q <= RX_IDLE;
            if (din) begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx.byte_valid = byte_valid_q;
  assign rx.byte_data  = byte_q;

endmodule

// File: rtl/x_top.sv
// Keypad calculator top: PS/2 receiver, scan-code decoder, accumulator engine
// over the regf register file, hex 7-segment driver and GPO.
module x_top
  import x_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REGF_ADDR_W = DEF_REGF_ADDR_W,
  parameter int REFRESH_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_data,
  input  logic        ps2_clk,
  output logic        push_AC,
  output logic        push_C,
  output logic [11:0] disp_ctrl,
  output logic [7:0]  gpo_out
);

  localparam int DEPTH = 1 << REGF_ADDR_W;

  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input op_e               opc);
    case (opc)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return (b == '0) ? '1 : a / b;
    endcase
  endfunction

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  x_if rx_bus ();

  x_ps2_rx u_ps2_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx_bus)
  );

  // Stage p0: break/extended filtering, latch one make code per key press.
  logic       brk_q, brk_d;
  logic       vld_p0_q, vld_p0_d;
  logic [7:0] code_p0_q, code_p0_d;

  always_comb begin
    brk_d     = brk_q;
    vld_p0_d  = 1'b0;
    code_p0_d = code_p0_q;
    if (rx_bus.byte_valid) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (rx_bus.byte_data == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_bus.byte_data != SC_EXT) begin
        vld_p0_d  = 1'b1;
        code_p0_d = rx_bus.byte_data;
      end
    end
  end

  // Stage p1: execute the make code against the register file.
  logic        push_ac_q, push_ac_d;
  logic        push_c_q, push_c_d;
  logic [15:0] disp_val;
  logic [7:0]  gpo_val;

  if (1) begin : regf
    logic [DATA_W-1:0] reg_1 [0:DEPTH-1];
    logic [DATA_W-1:0] reg_d [0:DEPTH-1];
    logic [DATA_W-1:0] operand;
    key_t              key;
    logic              active;
    op_e               cur_op;

    always_comb begin
      for (int i = 0; i < DEPTH; i++) reg_d[i] = reg_1[i];
      push_ac_d = 1'b0;
      push_c_d  = 1'b0;
      key       = decode_key(code_p0_q);
      active    = (reg_1[R_ACTIVE] != '0);
      cur_op    = op_e'(reg_1[R_OP][1:0]);
      operand   = active ? reg_1[R_ENTRY] : reg_1[R_ACC];
      if (vld_p0_q) begin
        reg_d[R_LAST]  = {{(DATA_W-8){1'b0}}, code_p0_q};
        reg_d[R_COUNT] = reg_1[R_COUNT] + DATA_W'(1);
        case (key.kind)
          K_DIGIT: begin
            reg_d[R_ENTRY]  = reg_1[R_ENTRY] * DATA_W'(10) + DATA_W'(key.digit);
            reg_d[R_ACTIVE] = DATA_W'(1);
          end
          K_OPER: begin
            if (active) reg_d[R_ACC] = alu(reg_1[R_ACC], reg_1[R_ENTRY], cur_op);
            reg_d[R_OP]     = DATA_W'(key.op);
            reg_d[R_ENTRY]  = '0;
            reg_d[R_ACTIVE] = '0;
          end
          K_ENTER: begin
            reg_d[R_ACC]    = alu(reg_1[R_ACC], operand, cur_op);
            reg_d[R_ENTRY]  = '0;
            reg_d[R_ACTIVE] = '0;
          end
          K_CLEAR: begin
            reg_d[R_ENTRY]  = '0;
            reg_d[R_ACTIVE] = '0;
            push_c_d        = 1'b1;
          end
          K_ALLCLR: begin
            reg_d[R_ACC]    = '0;
            reg_d[R_ENTRY]  = '0;
            reg_d[R_OP]     = DATA_W'(OP_ADD);
            reg_d[R_ACTIVE] = '0;
            push_ac_d       = 1'b1;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rst) reg_1[i] <= '0;
        else     reg_1[i] <= reg_d[i];
      end
    end

    assign disp_val = active ? reg_1[R_ENTRY][15:0] : reg_1[R_ACC][15:0];
    assign gpo_val  = reg_1[R_ACC][7:0];
  end

  // Stage p2: display multiplexing.
  logic [REFRESH_W+1:0] refresh_q, refresh_d;
  logic [11:0]          disp_q, disp_d;
  logic [1:0]           digit_sel;
  logic [3:0]           nib;

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_sel = refresh_q[REFRESH_W +: 2];
    nib       = disp_val[{digit_sel, 2'b00} +: 4];
    disp_d    = {~(4'b0001 << digit_sel), hex_seg(nib)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q     <= 1'b0;
      vld_p0_q  <= 1'b0;
      push_ac_q <= 1'b0;
      push_c_q  <= 1'b0;
      refresh_q <= '0;
      disp_q    <= 12'hEC0;
    end else begin
      brk_q     <= brk_d;
      vld_p0_q  <= vld_p0_d;
      push_ac_q <= push_ac_d;
      push_c_q  <= push_c_d;
      refresh_q <= refresh_d;
      disp_q    <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    code_p0_q <= code_p0_d;
  end

  assign push_AC   = push_ac_q;
  assign push_C    = push_c_q;
  assign disp_ctrl = disp_q;
  assign gpo_out   = gpo_val;

endmodule

// File: tb/tb_x_top.sv
// Bench for x_top: directed calculator scenarios followed by random key
// presses, all compared against a behavioural calculator model.
module tb_x_top;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        push_AC, push_C;
  logic [11:0] disp_ctrl;
  logic [7:0]  gpo_out;

  int checks = 0;
  int failures = 0;
  int ac_cnt = 0;
  int c_cnt = 0;

  logic [31:0] m_acc, m_entry, m_op, m_last, m_act, m_cnt;

  logic [7:0] kp_dig  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] top_dig [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] op_codes [4] = '{8'h79, 8'h7B, 8'h7C, 8'h4A};
  logic [7:0] unk_codes [3] = '{8'h1C, 8'h32, 8'h0D};
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  x_top #(.REFRESH_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_data  (ps2_data),
    .ps2_clk   (ps2_clk),
    .push_AC   (push_AC),
    .push_C    (push_C),
    .disp_ctrl (disp_ctrl),
    .gpo_out   (gpo_out)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (push_AC) ac_cnt++;
    if (push_C)  c_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (kp_dig[i] == c || top_dig[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    logic [63:0] p;
    case (op)
      0: return a + b;
      1: return a - b;
      2: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_entry = 0; m_op = 0; m_last = 0; m_act = 0; m_cnt = 0;
  endtask

  task automatic model_key(input logic [7:0] c);
    int d;
    logic [63:0] t;
    d = digit_of(c);
    m_last = {24'd0, c};
    m_cnt = m_cnt + 1;
    if (d >= 0) begin
      t = {32'd0, m_entry} * 64'd10 + 64'(d);
      m_entry = t[31:0];
      m_act = 1;
    end else if (c == 8'h79 || c == 8'h7B || c == 8'h7C || c == 8'h4A) begin
      if (m_act != 0) m_acc = calc(m_acc, m_entry, m_op);
      m_op = (c == 8'h79) ? 0 : (c == 8'h7B) ? 1 : (c == 8'h7C) ? 2 : 3;
      m_entry = 0; m_act = 0;
    end else if (c == 8'h5A) begin
      m_acc = calc(m_acc, (m_act != 0) ? m_entry : m_acc, m_op);
      m_entry = 0; m_act = 0;
    end else if (c == 8'h66) begin
      m_entry = 0; m_act = 0;
    end else if (c == 8'h76) begin
      m_acc = 0; m_entry = 0; m_op = 0; m_act = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  task automatic press(input logic [7:0] code, input logic ext);
    if (ext) send_frame(8'hE0, 1'b1);
    send_frame(code, 1'b1);
    if (ext) send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(code, 1'b1);
    model_key(code);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_r0"}, dut.regf.reg_1[0], m_acc);
    check({tag, "_r1"}, dut.regf.reg_1[1], m_entry);
    check({tag, "_r2"}, dut.regf.reg_1[2], m_op);
    check({tag, "_r3"}, dut.regf.reg_1[3], m_last);
    check({tag, "_r4"}, dut.regf.reg_1[4], m_act);
    check({tag, "_r5"}, dut.regf.reg_1[5], m_cnt);
    check({tag, "_gpo"}, {24'd0, gpo_out}, {24'd0, m_acc[7:0]});
  endtask

  task automatic check_disp(input string tag, input logic [15:0] val);
    logic [7:0] seen [4];
    for (int i = 0; i < 4; i++) seen[i] = 8'h00;
    repeat (20) begin
      @(negedge clk);
      case (disp_ctrl[11:8])
        4'b1110: seen[0] = disp_ctrl[7:0];
        4'b1101: seen[1] = disp_ctrl[7:0];
        4'b1011: seen[2] = disp_ctrl[7:0];
        4'b0111: seen[3] = disp_ctrl[7:0];
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_dig%0d", tag, i), {24'd0, seen[i]}, {24'd0, seg_tab[val[4*i +: 4]]});
  endtask

  initial begin
    int r;
    int idx;
    logic [7:0] code;
    logic ext;
    logic [31:0] v;

    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_disp", {20'd0, disp_ctrl}, 32'h0000_0EC0);
    check("rst_gpo", {24'd0, gpo_out}, 32'd0);
    check("rst_push", {30'd0, push_AC, push_C}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_disp", {20'd0, disp_ctrl}, 32'h0000_0EC0);
    check_regs("reset");

    press(8'h79, 1'b0); press(8'h16, 1'b0); press(8'h36, 1'b0); press(8'h5A, 1'b0);
    check("add16_r0", dut.regf.reg_1[0], 32'd16);
    check("add16_r2", dut.regf.reg_1[2], 32'd0);
    check("add16_gpo", {24'd0, gpo_out}, 32'h10);
    check_regs("add16");
    check_disp("add16", 16'h0010);

    press(8'h7C, 1'b0); press(8'h5A, 1'b0);
    check("square_r0", dut.regf.reg_1[0], 32'd256);
    check_regs("square");

    press(8'h7B, 1'b0); press(8'h25, 1'b0);
    check("type4_r1", dut.regf.reg_1[1], 32'd4);
    check_disp("type4", 16'h0004);
    press(8'h26, 1'b0);
    check_disp("type43", 16'h002B);
    press(8'h5A, 1'b0);
    check("sub43_r0", dut.regf.reg_1[0], 32'd213);
    check("sub43_gpo", {24'd0, gpo_out}, 32'hD5);
    check("sub43_r5", dut.regf.reg_1[5], 32'd10);
    check_disp("sub43", 16'h00D5);
    check_regs("sub43");

    press(8'h4A, 1'b0); press(8'h70, 1'b0); press(8'h5A, 1'b0);
    check("div0_r0", dut.regf.reg_1[0], 32'hFFFF_FFFF);
    ac_cnt = 0;
    press(8'h76, 1'b0);
    check("esc_r0", dut.regf.reg_1[0], 32'd0);
    check("esc_pulse_len", ac_cnt, 32'd1);
    check_regs("esc");

    c_cnt = 0;
    press(8'h6B, 1'b0); press(8'h66, 1'b0);
    check("clr_pulse_len", c_cnt, 32'd1);
    check("clr_r1", dut.regf.reg_1[1], 32'd0);
    check_regs("clr");

    send_frame(8'h16, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_regs("badstop");

    press(8'h7A, 1'b0); press(8'h5A, 1'b1);
    check("ext_enter_r0", dut.regf.reg_1[0], 32'd3);
    check_regs("ext_enter");

    send_frame(8'hF0, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2 * H) @(posedge clk);
    press(8'h2E, 1'b0);
    check("midrst_r1", dut.regf.reg_1[1], 32'd5);
    check("midrst_r5", dut.regf.reg_1[5], 32'd1);
    check_regs("midrst");

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      ext = ($urandom_range(0, 3) == 0);
      if (r < 50) begin
        idx = $urandom_range(0, 9);
        code = ($urandom_range(0, 1) == 0) ? kp_dig[idx] : top_dig[idx];
      end else if (r < 68) begin
        code = op_codes[$urandom_range(0, 3)];
      end else if (r < 80) begin
        code = 8'h5A;
      end else if (r < 86) begin
        code = 8'h66;
      end else if (r < 90) begin
        code = 8'h76;
      end else begin
        code = unk_codes[$urandom_range(0, 2)];
      end
      press(code, ext);
      check_regs($sformatf("rnd%0d", k));
      if (k % 8 == 7) begin
        v = (m_act != 0) ? m_entry : m_acc;
        check_disp($sformatf("rnd%0d", k), v[15:0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
